// File: rtl/fft_frame_scheduler_if.sv
// Handshake and status bundle between the frame scheduler, the S2P frame buffer and the FFT.
// The scheduler sits on the slave side; whoever drives frames and the FFT sits on the master side.
interface fft_frame_scheduler_if #(
  parameter int unsigned NUM_FRAMES = 64
);
  localparam int unsigned FCW = $clog2(NUM_FRAMES + 1);

  logic           enable;
  logic           s2p_valid;
  logic           fft_ready;
  logic           fft_done;
  logic           capture_en;
  logic           fft_start;
  logic           busy;
  logic [FCW-1:0] frame_cnt;
  logic [7:0]     drop_cnt;
  logic           overrun;
  logic           timeout_err;
  logic           all_done;

  modport master (
    output enable, s2p_valid, fft_ready, fft_done,
    input  capture_en, fft_start, busy, frame_cnt, drop_cnt, overrun, timeout_err, all_done
  );

  modport slave (
    input  enable, s2p_valid, fft_ready, fft_done,
    output capture_en, fft_start, busy, frame_cnt, drop_cnt, overrun, timeout_err, all_done
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Frame scheduler: captures one buffered frame at a time, hands it to the FFT, waits for
// completion, and tracks completed/dropped frames plus a watchdog on the FFT.
module fft_frame_scheduler #(
  parameter int unsigned NUM_FRAMES = 64,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  rst,
  fft_frame_scheduler_if.slave bus
);
  localparam int unsigned FCW = $clog2(NUM_FRAMES + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StStart,
    StWaitDone,
    StFinish
  } state_e;

  state_e         state_q, state_d;
  logic [WDW-1:0] wd_q;
  logic [FCW-1:0] frame_inc;
  logic           wd_expired;
  logic           in_flight;

  assign frame_inc  = bus.frame_cnt + 1'b1;
  assign wd_expired = (wd_q == WDW'(TIMEOUT));
  assign in_flight  = (state_q == StStart) || (state_q == StWaitDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StWaitFrame;
      end
      StWaitFrame: begin
        // A frame arriving together with enable falling is still taken.
        if (bus.s2p_valid)   state_d = StStart;
        else if (!bus.enable) state_d = StIdle;
      end
      StStart: begin
        // fft_start is always high here, so fft_ready alone marks the transfer.
        if (bus.fft_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.fft_done) begin
          if (frame_inc == FCW'(NUM_FRAMES)) state_d = StFinish;
          else if (bus.enable)               state_d = StWaitFrame;
          else                               state_d = StIdle;
        end else if (wd_expired) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        if (!bus.enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      wd_q            <= '0;
      bus.capture_en  <= 1'b0;
      bus.fft_start   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.all_done    <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.drop_cnt    <= '0;
      bus.overrun     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.capture_en <= (state_q == StWaitFrame) && bus.s2p_valid;
      bus.fft_start  <= (state_d == StStart);
      bus.busy       <= (state_d == StStart) || (state_d == StWaitDone);
      bus.all_done   <= (state_d == StFinish);
      wd_q           <= (state_q == StWaitDone) ? wd_q + 1'b1 : '0;

      if ((state_q == StIdle) && bus.enable) begin
        bus.frame_cnt   <= '0;
        bus.drop_cnt    <= '0;
        bus.overrun     <= 1'b0;
        bus.timeout_err <= 1'b0;
      end

      // No queueing: a frame arriving while one is in flight is lost.
      if (in_flight && bus.s2p_valid) begin
        bus.overrun <= 1'b1;
        if (bus.drop_cnt != 8'hff) bus.drop_cnt <= bus.drop_cnt + 8'd1;
      end

      if (state_q == StWaitDone) begin
        if (bus.fft_done)    bus.frame_cnt   <= frame_inc;
        else if (wd_expired) bus.timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler: a behavioural model queues the expected outputs of
// every cycle and a monitor compares them; directed scenarios add absolute checks.
module tb_fft_frame_scheduler;
  localparam int unsigned NF  = 4;
  localparam int unsigned TO  = 255;
  localparam int unsigned FCW = $clog2(NF + 1);

  localparam int M_IDLE  = 0;
  localparam int M_WAITF = 1;
  localparam int M_OFFER = 2;
  localparam int M_RUN   = 3;
  localparam int M_FIN   = 4;

  typedef struct packed {
    logic           cap;
    logic           st;
    logic           busy;
    logic [FCW-1:0] fc;
    logic [7:0]     dc;
    logic           ov;
    logic           to;
    logic           ad;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_frame_scheduler_if #(.NUM_FRAMES(NF)) bus ();

  fft_frame_scheduler #(.NUM_FRAMES(NF), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  obs_t smp;

  // Reference model: mode of the run, counters, and cycles spent offering / running the FFT.
  int m_mode  = M_IDLE;
  int m_fc    = 0;
  int m_dc    = 0;
  bit m_ov    = 1'b0;
  bit m_to    = 1'b0;
  int m_offer = 0;
  int m_run   = 0;

  function automatic obs_t cur_obs();
    obs_t o;
    o.cap  = bus.capture_en;
    o.st   = bus.fft_start;
    o.busy = bus.busy;
    o.fc   = bus.frame_cnt;
    o.dc   = bus.drop_cnt;
    o.ov   = bus.overrun;
    o.to   = bus.timeout_err;
    o.ad   = bus.all_done;
    return o;
  endfunction

  function automatic bit rbit(input int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit sv, input bit rdy, input bit dn);
    obs_t e;
    bit   cap;
    cap = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      m_fc   = 0;
      m_dc   = 0;
      m_ov   = 1'b0;
      m_to   = 1'b0;
    end else begin
      if ((m_mode == M_OFFER || m_mode == M_RUN) && sv) begin
        m_ov = 1'b1;
        if (m_dc < 255) m_dc++;
      end
      case (m_mode)
        M_IDLE: if (en) begin
          m_fc   = 0;
          m_dc   = 0;
          m_ov   = 1'b0;
          m_to   = 1'b0;
          m_mode = M_WAITF;
        end
        M_WAITF: if (sv) begin
          cap     = 1'b1;
          m_mode  = M_OFFER;
          m_offer = 0;
        end else if (!en) begin
          m_mode = M_IDLE;
        end
        M_OFFER: if (rdy) begin
          m_mode = M_RUN;
          m_run  = 0;
        end else begin
          m_offer++;
        end
        M_RUN: begin
          m_run++;
          if (dn) begin
            m_fc++;
            if (m_fc == int'(NF)) m_mode = M_FIN;
            else if (en)          m_mode = M_WAITF;
            else                  m_mode = M_IDLE;
          end else if (m_run > int'(TO)) begin
            m_to   = 1'b1;
            m_mode = M_FIN;
          end
        end
        M_FIN: if (!en) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    e.cap  = cap;
    e.st   = (m_mode == M_OFFER);
    e.busy = (m_mode == M_OFFER) || (m_mode == M_RUN);
    e.fc   = m_fc[FCW-1:0];
    e.dc   = m_dc[7:0];
    e.ov   = m_ov;
    e.to   = m_to;
    e.ad   = (m_mode == M_FIN);
    exp_q.push_back(e);
  endtask

  // One clock cycle: sample the outputs valid during it, drive its inputs, advance the model.
  task automatic cyc(input bit r, input bit en, input bit sv, input bit rdy, input bit dn);
    @(negedge clk);
    smp           = cur_obs();
    rst           = r;
    bus.enable    = en;
    bus.s2p_valid = sv;
    bus.fft_ready = rdy;
    bus.fft_done  = dn;
    model_step(r, en, sv, rdy, dn);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, rbit(50), rbit(50), rbit(50), rbit(50));
  endtask

  initial begin : monitor
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = cur_obs();
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display({"FAIL outputs @%0t: got cap=%b st=%b busy=%b fc=%0d dc=%0d ov=%b to=%b ad=%b",
                    " expected cap=%b st=%b busy=%b fc=%0d dc=%0d ov=%b to=%b ad=%b"},
                   $time, g.cap, g.st, g.busy, g.fc, g.dc, g.ov, g.to, g.ad,
                   e.cap, e.st, e.busy, e.fc, e.dc, e.ov, e.to, e.ad);
        end
      end
    end
  end

  initial begin : stim
    int          caps;
    int          starts;
    int          st_cycles;
    int          xfers;
    bit          prev_st;
    bit          rdy;
    bit          dn;
    int unsigned dn_pct;

    bus.enable    = 1'b0;
    bus.s2p_valid = 1'b0;
    bus.fft_ready = 1'b0;
    bus.fft_done  = 1'b0;

    // Reset with random inputs, then one idle cycle to observe the reset state.
    do_reset(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset outputs zero", int'(smp), 0);

    // Nominal run: frame every 16 cycles, FFT always ready, done on the 5th wait cycle.
    do_reset(2);
    caps = 0; starts = 0; prev_st = 1'b0;
    for (int i = 0; i < 80; i++) begin
      dn = (m_mode == M_RUN) && (m_run == 4);
      cyc(1'b0, 1'b1, (i % 16) == 3, 1'b1, dn);
      if (smp.cap) caps++;
      if (smp.st && !prev_st) starts++;
      prev_st = smp.st;
    end
    check("nominal capture pulses", caps, 4);
    check("nominal start pulses", starts, 4);
    check("nominal frame_cnt", int'(smp.fc), 4);
    check("nominal all_done", int'(smp.ad), 1);
    check("nominal drop_cnt", int'(smp.dc), 0);

    // Backpressure: FFT not ready for the first 3 START cycles.
    do_reset(2);
    caps = 0; st_cycles = 0; xfers = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = !((m_mode == M_OFFER) && (m_offer < 3));
      dn  = (m_mode == M_RUN) && (m_run == 4);
      cyc(1'b0, 1'b1, i == 3, rdy, dn);
      if (smp.cap) caps++;
      if (smp.st) st_cycles++;
      if (smp.st && rdy) xfers++;
    end
    check("backpressure start cycles", st_cycles, 4);
    check("backpressure transfers", xfers, 1);
    check("backpressure captures", caps, 1);

    // Overrun: FFT takes 20 cycles, so every other frame plus each frame on fft_done is lost.
    do_reset(2);
    for (int i = 0; i < 140; i++) begin
      dn = (m_mode == M_RUN) && (m_run == 19);
      cyc(1'b0, 1'b1, ((i % 16) == 3) || dn, 1'b1, dn);
    end
    check("overrun frame_cnt", int'(smp.fc), 4);
    check("overrun drop_cnt", int'(smp.dc), 8);
    check("overrun flag", int'(smp.ov), 1);

    // Watchdog: FFT never finishes; frame accepted at step 3, waiting starts at step 5.
    do_reset(2);
    for (int i = 0; i < 270; i++) begin
      cyc(1'b0, 1'b1, i == 3, 1'b1, 1'b0);
      if (i == 260) begin
        check("watchdog not yet expired", int'(smp.to), 0);
        check("watchdog still busy", int'(smp.busy), 1);
      end
      if (i == 261) begin
        check("watchdog timeout_err", int'(smp.to), 1);
        check("watchdog all_done", int'(smp.ad), 1);
        check("watchdog frame_cnt", int'(smp.fc), 0);
        check("watchdog busy cleared", int'(smp.busy), 0);
      end
    end

    // Control: enable drop mid-frame, re-enable clears counters, reset during WAIT_DONE.
    do_reset(2);
    for (int i = 0; i < 32; i++) begin
      dn = (m_mode == M_RUN) && (m_run == 4);
      cyc(i == 26, !(i >= 6 && i < 16), (i == 3) || (i == 20) || (i == 24), 1'b1, dn);
      if (i == 12) begin
        check("enable drop frame completes", int'(smp.fc), 1);
        check("enable drop returns idle", int'(smp.busy), 0);
      end
      if (i == 18) check("re-enable clears frame_cnt", int'(smp.fc), 0);
      if (i == 26) check("drop before reset", int'(smp.dc), 1);
      if (i == 27) check("reset in wait_done", int'(smp), 0);
    end

    // Randomized traffic, with stretches where the FFT never finishes.
    do_reset(2);
    dn_pct = 12;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) dn_pct = (i % 1000 == 0) ? 0 : 12;
      cyc(rbit(1), rbit(90), rbit(15), rbit(60), rbit(dn_pct));
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
